// File: rtl/instruction_fetch.sv
// Fetch stage: issues one bus read per start pulse and hands the word to decode over valid/ready.
// Optional misaligned-PC rejection is enabled by defining IF_MISALIGN_CHECK_EN.
module instruction_fetch #(
    parameter int BUS_TIMEOUT = 255
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [31:0] i_PC,
    input  logic        i_fetch_start,
    input  logic        i_flush,
    output logic [31:0] o_bus_addr,
    output logic        o_bus_read_DV,
    input  logic [31:0] i_bus_data,
    input  logic        i_bus_DV,
    output logic [31:0] o_instr,
    output logic [31:0] o_instr_PC,
    output logic        o_instr_DV,
    input  logic        i_instr_ready,
    output logic        o_busy,
    output logic        o_bus_error,
    output logic        o_misaligned
);

    localparam logic [31:0] NOP        = 32'h0000_0013;
    localparam logic [7:0]  TIMEOUT_LIM = BUS_TIMEOUT[7:0];
    localparam bit          TIMEOUT_EN  = (BUS_TIMEOUT != 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_VALID,
        S_DRAIN
    } state_t;

    state_t      r_state;
    logic [7:0]  r_cnt;
    logic [31:0] r_bus_addr;
    logic        r_bus_read_dv;
    logic [31:0] r_instr;
    logic [31:0] r_instr_pc;
    logic        r_instr_dv;
    logic        r_busy;
    logic        r_bus_error;
    logic        r_misaligned;

    logic [7:0]  w_cnt_next;
    logic        w_timeout_hit;
    logic        w_timeout_arm;
    logic        w_pc_misaligned;

    // The error pulse is raised as the counter reaches the limit; the exit to IDLE follows a cycle later.
    assign w_cnt_next    = r_cnt + 8'd1;
    assign w_timeout_hit = TIMEOUT_EN && (r_cnt == TIMEOUT_LIM);
    assign w_timeout_arm = TIMEOUT_EN && (w_cnt_next == TIMEOUT_LIM);

`ifdef IF_MISALIGN_CHECK_EN
    assign w_pc_misaligned = (i_PC[1:0] != 2'b00);
`else
    assign w_pc_misaligned = 1'b0;
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state       <= S_IDLE;
            r_cnt         <= 8'd0;
            r_bus_addr    <= 32'd0;
            r_bus_read_dv <= 1'b0;
            r_instr       <= NOP;
            r_instr_pc    <= 32'd0;
            r_instr_dv    <= 1'b0;
            r_busy        <= 1'b0;
            r_bus_error   <= 1'b0;
            r_misaligned  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every register updating from pre-edge values.
            r_bus_read_dv <= 1'b0;
            r_bus_error   <= 1'b0;
            r_misaligned  <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (i_fetch_start) begin
                        if (w_pc_misaligned) begin
                            r_misaligned <= 1'b1;
                        end else begin
                            r_bus_addr    <= i_PC;
                            r_instr_pc    <= i_PC;
                            r_bus_read_dv <= 1'b1;
                            r_busy        <= 1'b1;
                            r_state       <= S_REQ;
                        end
                    end
                end

                S_REQ: begin
                    r_cnt   <= 8'd0;
                    r_state <= i_flush ? S_DRAIN : S_WAIT;
                end

                S_WAIT: begin
                    if (w_timeout_hit) begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else if (i_bus_DV) begin
                        if (i_flush) begin
                            r_busy  <= 1'b0;
                            r_state <= S_IDLE;
                        end else begin
                            r_instr    <= i_bus_data;
                            r_instr_dv <= 1'b1;
                            r_state    <= S_VALID;
                        end
                    end else begin
                        r_cnt       <= w_cnt_next;
                        r_bus_error <= w_timeout_arm;
                        if (i_flush) begin
                            r_state <= S_DRAIN;
                        end
                    end
                end

                S_VALID: begin
                    if (i_instr_ready || i_flush) begin
                        r_instr_dv <= 1'b0;
                        r_busy     <= 1'b0;
                        r_state    <= S_IDLE;
                    end
                end

                S_DRAIN: begin
                    if (w_timeout_hit || i_bus_DV) begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt       <= w_cnt_next;
                        r_bus_error <= w_timeout_arm;
                    end
                end

                default: begin
                    r_instr_dv <= 1'b0;
                    r_busy     <= 1'b0;
                    r_state    <= S_IDLE;
                end
            endcase
        end
    end

    assign o_bus_addr    = r_bus_addr;
    assign o_bus_read_DV = r_bus_read_dv;
    assign o_instr       = r_instr;
    assign o_instr_PC    = r_instr_pc;
    assign o_instr_DV    = r_instr_dv;
    assign o_busy        = r_busy;
    assign o_bus_error   = r_bus_error;
    assign o_misaligned  = r_misaligned;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: handshake, stall, flush, timeout, misalignment and reset.
// Build with IF_MISALIGN_CHECK_EN defined to exercise the misaligned-PC rejection path.
module tb_instruction_fetch;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc;
    logic        fetch_start;
    logic        flush;
    logic [31:0] bus_addr;
    logic        bus_read_dv;
    logic [31:0] bus_data;
    logic        bus_dv;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_dv;
    logic        instr_ready;
    logic        busy;
    logic        bus_error;
    logic        misaligned;

    int n_cmp = 0;
    int n_mis = 0;

    instruction_fetch #(.BUS_TIMEOUT(4)) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_PC          (pc),
        .i_fetch_start (fetch_start),
        .i_flush       (flush),
        .o_bus_addr    (bus_addr),
        .o_bus_read_DV (bus_read_dv),
        .i_bus_data    (bus_data),
        .i_bus_DV      (bus_dv),
        .o_instr       (instr),
        .o_instr_PC    (instr_pc),
        .o_instr_DV    (instr_dv),
        .i_instr_ready (instr_ready),
        .o_busy        (busy),
        .o_bus_error   (bus_error),
        .o_misaligned  (misaligned)
    );

    always #5 clk = ~clk;

    // Advance one cycle; outputs are then read 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; pc = '0; fetch_start = 0; flush = 0;
        bus_data = '0; bus_dv = 0; instr_ready = 0;
        step(); step();
        n_cmp++; if (instr !== NOP) begin n_mis++; $display("FAIL reset_instr: got %h want %h", instr, NOP); end
        n_cmp++; if (instr_pc !== 32'd0) begin n_mis++; $display("FAIL reset_instr_pc: got %h want 0", instr_pc); end
        n_cmp++; if (bus_addr !== 32'd0) begin n_mis++; $display("FAIL reset_bus_addr: got %h want 0", bus_addr); end
        n_cmp++; if ({bus_read_dv, instr_dv, busy, bus_error, misaligned} !== 5'b0)
            begin n_mis++; $display("FAIL reset_strobes: got %b want 00000", {bus_read_dv, instr_dv, busy, bus_error, misaligned}); end
        rst = 1'b0;
        step();
    endtask

    task automatic test_basic_fetch();
        pc = 32'h100; fetch_start = 1;
        step();                                  // cycle 1
        fetch_start = 0;
        n_cmp++; if (bus_read_dv !== 1'b1) begin n_mis++; $display("FAIL basic_req_c1: got %b want 1", bus_read_dv); end
        n_cmp++; if (bus_addr !== 32'h100) begin n_mis++; $display("FAIL basic_addr: got %h want 00000100", bus_addr); end
        n_cmp++; if (busy !== 1'b1) begin n_mis++; $display("FAIL basic_busy: got %b want 1", busy); end
        step();                                  // cycle 2
        n_cmp++; if (bus_read_dv !== 1'b0) begin n_mis++; $display("FAIL basic_req_c2: got %b want 0", bus_read_dv); end
        step();                                  // cycle 3: response
        bus_dv = 1; bus_data = 32'h0050_0093;
        n_cmp++; if (instr_dv !== 1'b0) begin n_mis++; $display("FAIL basic_dv_c3: got %b want 0", instr_dv); end
        step();                                  // cycle 4
        bus_dv = 0; bus_data = '0;
        n_cmp++; if (instr_dv !== 1'b1) begin n_mis++; $display("FAIL basic_dv_c4: got %b want 1", instr_dv); end
        n_cmp++; if (instr !== 32'h0050_0093) begin n_mis++; $display("FAIL basic_instr: got %h want 00500093", instr); end
        n_cmp++; if (instr_pc !== 32'h100) begin n_mis++; $display("FAIL basic_instr_pc: got %h want 00000100", instr_pc); end
    endtask

    // Continues from VALID left by test_basic_fetch.
    task automatic test_stall_and_back_to_back();
        for (int i = 0; i < 5; i++) begin
            step();
            n_cmp++; if (instr_dv !== 1'b1 || instr !== 32'h0050_0093)
                begin n_mis++; $display("FAIL stall_hold[%0d]: got dv=%b instr=%h want dv=1 instr=00500093", i, instr_dv, instr); end
        end
        instr_ready = 1;
        step();
        instr_ready = 0;
        n_cmp++; if (instr_dv !== 1'b0 || busy !== 1'b0)
            begin n_mis++; $display("FAIL stall_accept: got dv=%b busy=%b want 0 0", instr_dv, busy); end
        pc = 32'h104; fetch_start = 1;
        step();
        fetch_start = 0;
        n_cmp++; if (bus_read_dv !== 1'b1 || bus_addr !== 32'h104)
            begin n_mis++; $display("FAIL b2b_req: got rd=%b addr=%h want 1 00000104", bus_read_dv, bus_addr); end
        step();                                  // WAIT, zero-wait response
        bus_dv = 1; bus_data = 32'h00A0_0113;
        step();
        bus_dv = 0;
        n_cmp++; if (instr_dv !== 1'b1 || instr !== 32'h00A0_0113 || instr_pc !== 32'h104)
            begin n_mis++; $display("FAIL b2b_valid: got dv=%b instr=%h pc=%h want 1 00a00113 00000104", instr_dv, instr, instr_pc); end
        instr_ready = 1;
        step();
        instr_ready = 0;
    endtask

    task automatic test_flush();
        pc = 32'h180; fetch_start = 1;
        step();                                  // cycle 1 REQ
        fetch_start = 0;
        step();                                  // cycle 2 WAIT
        flush = 1;
        step();                                  // cycle 3 DRAIN
        flush = 0;
        n_cmp++; if (busy !== 1'b1) begin n_mis++; $display("FAIL flush_drain_busy: got %b want 1", busy); end
        step(); step();                          // cycle 5: orphaned response
        bus_dv = 1; bus_data = 32'hDEAD_BEEF;
        step();
        bus_dv = 0;
        n_cmp++; if (instr_dv !== 1'b0 || busy !== 1'b0 || bus_error !== 1'b0)
            begin n_mis++; $display("FAIL flush_discard: got dv=%b busy=%b err=%b want 0 0 0", instr_dv, busy, bus_error); end
        pc = 32'h200; fetch_start = 1;
        step();
        fetch_start = 0;
        step();
        bus_dv = 1; bus_data = 32'h0010_8093;
        step();
        bus_dv = 0;
        n_cmp++; if (instr_dv !== 1'b1 || instr !== 32'h0010_8093 || instr_pc !== 32'h200)
            begin n_mis++; $display("FAIL flush_next: got dv=%b instr=%h pc=%h want 1 00108093 00000200", instr_dv, instr, instr_pc); end
        // Flush in VALID drops the instruction.
        flush = 1;
        step();
        flush = 0;
        n_cmp++; if (instr_dv !== 1'b0 || busy !== 1'b0)
            begin n_mis++; $display("FAIL flush_valid: got dv=%b busy=%b want 0 0", instr_dv, busy); end
        // Flush coincident with the response in WAIT.
        pc = 32'h240; fetch_start = 1;
        step();
        fetch_start = 0;
        step();
        flush = 1; bus_dv = 1; bus_data = 32'h1234_5678;
        step();
        flush = 0; bus_dv = 0;
        n_cmp++; if (instr_dv !== 1'b0 || busy !== 1'b0 || instr === 32'h1234_5678)
            begin n_mis++; $display("FAIL flush_with_data: got dv=%b busy=%b instr=%h want 0 0 not-12345678", instr_dv, busy, instr); end
    endtask

    task automatic test_timeout();
        logic exp_err;
        logic exp_busy;
        pc = 32'h300; fetch_start = 1;
        step();                                  // cycle 1
        fetch_start = 0;
        for (int c = 2; c <= 8; c++) begin
            step();
            exp_err  = (c == 6);
            exp_busy = (c <= 6);
            n_cmp++; if (bus_error !== exp_err || busy !== exp_busy || instr_dv !== 1'b0)
                begin n_mis++; $display("FAIL timeout_c%0d: got err=%b busy=%b dv=%b want %b %b 0", c, bus_error, busy, instr_dv, exp_err, exp_busy); end
        end
    endtask

    task automatic test_misalign();
        pc = 32'h102; fetch_start = 1;
        step();
        fetch_start = 0;
`ifdef IF_MISALIGN_CHECK_EN
        n_cmp++; if (misaligned !== 1'b1 || bus_read_dv !== 1'b0 || busy !== 1'b0)
            begin n_mis++; $display("FAIL misalign_c1: got mis=%b rd=%b busy=%b want 1 0 0", misaligned, bus_read_dv, busy); end
        step();
        n_cmp++; if (misaligned !== 1'b0 || bus_read_dv !== 1'b0)
            begin n_mis++; $display("FAIL misalign_c2: got mis=%b rd=%b want 0 0", misaligned, bus_read_dv); end
`else
        n_cmp++; if (misaligned !== 1'b0 || bus_read_dv !== 1'b1 || bus_addr !== 32'h102)
            begin n_mis++; $display("FAIL unaligned_req: got mis=%b rd=%b addr=%h want 0 1 00000102", misaligned, bus_read_dv, bus_addr); end
        step();
        bus_dv = 1; bus_data = 32'h0000_0073;
        step();
        bus_dv = 0;
        n_cmp++; if (instr_dv !== 1'b1 || instr_pc !== 32'h102)
            begin n_mis++; $display("FAIL unaligned_valid: got dv=%b pc=%h want 1 00000102", instr_dv, instr_pc); end
        instr_ready = 1;
        step();
        instr_ready = 0;
`endif
    endtask

    task automatic test_reset_mid_wait();
        pc = 32'h400; fetch_start = 1;
        step();
        fetch_start = 0;
        step();                                  // WAIT
        #2 rst = 1'b1;
        #1;
        n_cmp++; if (busy !== 1'b0 || bus_addr !== 32'd0 || instr_pc !== 32'd0 || instr !== NOP)
            begin n_mis++; $display("FAIL async_reset: got busy=%b addr=%h pc=%h instr=%h want 0 0 0 00000013", busy, bus_addr, instr_pc, instr); end
        step();
        rst = 1'b0;
        bus_dv = 1; bus_data = 32'hCAFE_F00D;
        step();
        bus_dv = 0;
        step();
        n_cmp++; if (instr_dv !== 1'b0 || instr !== NOP || busy !== 1'b0)
            begin n_mis++; $display("FAIL reset_ignore_resp: got dv=%b instr=%h busy=%b want 0 00000013 0", instr_dv, instr, busy); end
    endtask

    initial begin
        test_reset();
        test_basic_fetch();
        test_stall_and_back_to_back();
        test_flush();
        test_timeout();
        test_misalign();
        test_reset_mid_wait();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
